// File: rtl/axi_lite_control_slave.sv
// AXI4-Lite control slave: CTRL register (ap_start/ap_done/ap_idle) plus NUM_ARGS
// byte-strobed argument registers driving the kernel's start and argument inputs.
module axi_lite_control_slave #(
    parameter int unsigned AXI_ADDR_BITS = 6,
    parameter int unsigned AXI_DATA_BITS = 32,
    parameter int unsigned AXI_STRB_BITS = AXI_DATA_BITS / 8,
    parameter int unsigned NUM_ARGS      = 4
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              s_axi_control_AWVALID,
    output logic                              s_axi_control_AWREADY,
    input  logic [AXI_ADDR_BITS-1:0]          s_axi_control_AWADDR,
    input  logic                              s_axi_control_WVALID,
    output logic                              s_axi_control_WREADY,
    input  logic [AXI_DATA_BITS-1:0]          s_axi_control_WDATA,
    input  logic [AXI_STRB_BITS-1:0]          s_axi_control_WSTRB,
    output logic                              s_axi_control_BVALID,
    input  logic                              s_axi_control_BREADY,
    output logic [1:0]                        s_axi_control_BRESP,
    input  logic                              s_axi_control_ARVALID,
    output logic                              s_axi_control_ARREADY,
    input  logic [AXI_ADDR_BITS-1:0]          s_axi_control_ARADDR,
    output logic                              s_axi_control_RVALID,
    input  logic                              s_axi_control_RREADY,
    output logic [AXI_DATA_BITS-1:0]          s_axi_control_RDATA,
    output logic [1:0]                        s_axi_control_RRESP,
    output logic                              ap_start,
    input  logic                              ap_done,
    input  logic                              ap_idle,
    input  logic                              ap_ready,
    output logic [NUM_ARGS*AXI_DATA_BITS-1:0] args
);

    localparam int unsigned WORD_BITS = AXI_ADDR_BITS - 2;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t                 w_state_q, w_state_d;
    r_state_t                 r_state_q, r_state_d;
    logic [WORD_BITS-1:0]     aw_word_q, aw_word_d;
    logic [1:0]               bresp_q, bresp_d;
    logic [AXI_DATA_BITS-1:0] rdata_q, rdata_d;
    logic [1:0]               rresp_q, rresp_d;
    logic                     ap_start_q, ap_start_d;
    logic                     ap_done_q, ap_done_d;
    logic [AXI_DATA_BITS-1:0] args_q [NUM_ARGS];
    logic [AXI_DATA_BITS-1:0] args_d [NUM_ARGS];

    logic [WORD_BITS-1:0]     ar_word;
    logic                     aw_ctrl, ar_ctrl, aw_mapped, ar_mapped;
    logic [NUM_ARGS-1:0]      aw_arg, ar_arg;
    logic                     w_fire, ar_fire;
    logic [AXI_DATA_BITS-1:0] rd_val;
    logic                     unused_addr_lsbs;

    assign unused_addr_lsbs = ^{s_axi_control_AWADDR[1:0], s_axi_control_ARADDR[1:0]};
    assign ar_word = s_axi_control_ARADDR[AXI_ADDR_BITS-1:2];
    assign w_fire  = (w_state_q == W_DATA) && s_axi_control_WVALID;
    assign ar_fire = (r_state_q == R_IDLE) && s_axi_control_ARVALID;

    always_comb begin
        aw_ctrl = (aw_word_q == '0);
        ar_ctrl = (ar_word == '0);
        aw_arg  = '0;
        ar_arg  = '0;
        for (int unsigned i = 0; i < NUM_ARGS; i++) begin
            aw_arg[i] = (aw_word_q == WORD_BITS'(4 + i));
            ar_arg[i] = (ar_word == WORD_BITS'(4 + i));
        end
        aw_mapped = aw_ctrl || (|aw_arg);
        ar_mapped = ar_ctrl || (|ar_arg);
    end

    // Write channel FSM and register commit.
    always_comb begin
        w_state_d  = w_state_q;
        aw_word_d  = aw_word_q;
        bresp_d    = bresp_q;
        args_d     = args_q;
        ap_start_d = ap_start_q;
        ap_done_d  = ap_done_q;
        case (w_state_q)
            W_IDLE: if (s_axi_control_AWVALID) begin
                aw_word_d = s_axi_control_AWADDR[AXI_ADDR_BITS-1:2];
                w_state_d = W_DATA;
            end
            W_DATA: if (s_axi_control_WVALID) begin
                bresp_d   = aw_mapped ? 2'b00 : 2'b10;
                w_state_d = W_RESP;
            end
            W_RESP: if (s_axi_control_BREADY) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
        for (int unsigned i = 0; i < NUM_ARGS; i++) begin
            if (w_fire && aw_arg[i]) begin
                for (int unsigned k = 0; k < AXI_STRB_BITS; k++) begin
                    if (s_axi_control_WSTRB[k]) args_d[i][8*k +: 8] = s_axi_control_WDATA[8*k +: 8];
                end
            end
        end
        // Set beats clear for both sticky CTRL bits, hence the ordering.
        if (ap_ready) ap_start_d = 1'b0;
        if (w_fire && aw_ctrl && s_axi_control_WSTRB[0] && s_axi_control_WDATA[0]) ap_start_d = 1'b1;
        if (ar_fire && ar_ctrl) ap_done_d = 1'b0;
        if (ap_done) ap_done_d = 1'b1;
    end

    // Read channel FSM; the value is taken from pre-update register state.
    always_comb begin
        r_state_d = r_state_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rd_val    = '0;
        if (ar_ctrl) begin
            rd_val[0] = ap_start_q;
            rd_val[1] = ap_done_q;
            rd_val[2] = ap_idle;
        end
        for (int unsigned i = 0; i < NUM_ARGS; i++) begin
            if (ar_arg[i]) rd_val = args_q[i];
        end
        case (r_state_q)
            R_IDLE: if (s_axi_control_ARVALID) begin
                rdata_d   = rd_val;
                rresp_d   = ar_mapped ? 2'b00 : 2'b10;
                r_state_d = R_DATA;
            end
            R_DATA: if (s_axi_control_RREADY) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            w_state_q  <= W_IDLE;
            r_state_q  <= R_IDLE;
            aw_word_q  <= '0;
            bresp_q    <= '0;
            rdata_q    <= '0;
            rresp_q    <= '0;
            ap_start_q <= 1'b0;
            ap_done_q  <= 1'b0;
            args_q     <= '{default: '0};
        end else begin
            w_state_q  <= w_state_d;
            r_state_q  <= r_state_d;
            aw_word_q  <= aw_word_d;
            bresp_q    <= bresp_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            ap_start_q <= ap_start_d;
            ap_done_q  <= ap_done_d;
            args_q     <= args_d;
        end
    end

    always_comb begin
        args = '0;
        for (int unsigned i = 0; i < NUM_ARGS; i++) begin
            args[i*AXI_DATA_BITS +: AXI_DATA_BITS] = args_q[i];
        end
    end

    assign s_axi_control_AWREADY = (w_state_q == W_IDLE);
    assign s_axi_control_WREADY  = (w_state_q == W_DATA);
    assign s_axi_control_BVALID  = (w_state_q == W_RESP);
    assign s_axi_control_BRESP   = bresp_q;
    assign s_axi_control_ARREADY = (r_state_q == R_IDLE);
    assign s_axi_control_RVALID  = (r_state_q == R_DATA);
    assign s_axi_control_RDATA   = rdata_q;
    assign s_axi_control_RRESP   = rresp_q;
    assign ap_start              = ap_start_q;

endmodule

// File: tb/tb_axi_lite_control_slave.sv
// Directed bench for axi_lite_control_slave: a table of AXI-Lite accesses plus
// hand-written sequences for ap_start/ap_done handshakes, backpressure and reset.
module tb_axi_lite_control_slave;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic         awready, wready, bvalid, arready, rvalid;
    logic [5:0]   awaddr = '0, araddr = '0;
    logic [31:0]  wdata = '0, rdata;
    logic [3:0]   wstrb = '0;
    logic [1:0]   bresp, rresp;
    logic         ap_start_o;
    logic         ap_done_i = 1'b0, ap_idle_i = 1'b0, ap_ready_i = 1'b0;
    logic [127:0] args_o;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    axi_lite_control_slave #(
        .AXI_ADDR_BITS(6),
        .AXI_DATA_BITS(32),
        .AXI_STRB_BITS(4),
        .NUM_ARGS(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .s_axi_control_AWVALID(awvalid),
        .s_axi_control_AWREADY(awready),
        .s_axi_control_AWADDR(awaddr),
        .s_axi_control_WVALID(wvalid),
        .s_axi_control_WREADY(wready),
        .s_axi_control_WDATA(wdata),
        .s_axi_control_WSTRB(wstrb),
        .s_axi_control_BVALID(bvalid),
        .s_axi_control_BREADY(bready),
        .s_axi_control_BRESP(bresp),
        .s_axi_control_ARVALID(arvalid),
        .s_axi_control_ARREADY(arready),
        .s_axi_control_ARADDR(araddr),
        .s_axi_control_RVALID(rvalid),
        .s_axi_control_RREADY(rready),
        .s_axi_control_RDATA(rdata),
        .s_axi_control_RRESP(rresp),
        .ap_start(ap_start_o),
        .ap_done(ap_done_i),
        .ap_idle(ap_idle_i),
        .ap_ready(ap_ready_i),
        .args(args_o)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Write with optional ap_ready during the W handshake; hold_b leaves BREADY low.
    task automatic axi_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input logic ready_at_w, input logic hold_b, output logic [1:0] resp);
        int n;
        @(negedge clock);
        awvalid = 1'b1;
        awaddr  = addr;
        n = 0;
        while (!awready && n < 20) begin @(negedge clock); n++; end
        check("awready", awready, 1'b1);
        @(negedge clock);
        awvalid = 1'b0;
        check("wready", wready, 1'b1);
        wvalid = 1'b1;
        wdata  = data;
        wstrb  = strb;
        ap_ready_i = ready_at_w;
        @(negedge clock);
        wvalid = 1'b0;
        ap_ready_i = 1'b0;
        check("b_latency", bvalid, 1'b1);
        resp = bresp;
        if (!hold_b) begin
            bready = 1'b1;
            @(negedge clock);
            bready = 1'b0;
        end
    endtask

    // Read with optional ap_done pulse during the AR handshake.
    task automatic axi_read(input logic [5:0] addr, input logic done_at_ar,
                            output logic [31:0] data, output logic [1:0] resp);
        int n;
        @(negedge clock);
        arvalid = 1'b1;
        araddr  = addr;
        n = 0;
        while (!arready && n < 20) begin @(negedge clock); n++; end
        check("arready", arready, 1'b1);
        ap_done_i = done_at_ar;
        @(negedge clock);
        arvalid   = 1'b0;
        ap_done_i = 1'b0;
        check("r_latency", rvalid, 1'b1);
        data = rdata;
        resp = rresp;
        rready = 1'b1;
        @(negedge clock);
        rready = 1'b0;
    endtask

    typedef struct {
        logic        is_wr;
        logic [5:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end

    initial begin
        vec_t        vecs[16];
        logic [31:0] rd;
        logic [1:0]  rs;

        vecs[0]  = '{1'b0, 6'h00, 32'h0,        4'h0, 32'h00000000, 2'b00};
        vecs[1]  = '{1'b1, 6'h14, 32'hDEADBEEF, 4'hF, 32'h0,        2'b00};
        vecs[2]  = '{1'b1, 6'h14, 32'h00001200, 4'h2, 32'h0,        2'b00};
        vecs[3]  = '{1'b0, 6'h14, 32'h0,        4'h0, 32'hDEAD12EF, 2'b00};
        vecs[4]  = '{1'b1, 6'h10, 32'h12345678, 4'hF, 32'h0,        2'b00};
        vecs[5]  = '{1'b1, 6'h10, 32'hAABBCCDD, 4'h9, 32'h0,        2'b00};
        vecs[6]  = '{1'b0, 6'h10, 32'h0,        4'h0, 32'hAA3456DD, 2'b00};
        vecs[7]  = '{1'b1, 6'h1C, 32'hCAFEF00D, 4'hF, 32'h0,        2'b00};
        vecs[8]  = '{1'b0, 6'h1C, 32'h0,        4'h0, 32'hCAFEF00D, 2'b00};
        vecs[9]  = '{1'b1, 6'h3C, 32'hFFFFFFFF, 4'hF, 32'h0,        2'b10};
        vecs[10] = '{1'b0, 6'h3C, 32'h0,        4'h0, 32'h00000000, 2'b10};
        vecs[11] = '{1'b1, 6'h04, 32'h00000001, 4'hF, 32'h0,        2'b10};
        vecs[12] = '{1'b0, 6'h04, 32'h0,        4'h0, 32'h00000000, 2'b10};
        vecs[13] = '{1'b1, 6'h16, 32'h11111111, 4'h1, 32'h0,        2'b00};
        vecs[14] = '{1'b0, 6'h17, 32'h0,        4'h0, 32'hDEAD1211, 2'b00};
        vecs[15] = '{1'b1, 6'h00, 32'h00000006, 4'hF, 32'h0,        2'b00};

        repeat (3) @(negedge clock);
        check("rst_bvalid", bvalid, 1'b0);
        reset = 1'b1;
        @(negedge clock);
        check("rst_awready", awready, 1'b1);
        check("rst_arready", arready, 1'b1);
        check("rst_rvalid",  rvalid, 1'b0);
        check("rst_outs", {ap_start_o, bresp, rresp, rdata}, '0);
        check("rst_args", args_o, '0);

        for (int i = 0; i < 16; i++) begin
            if (vecs[i].is_wr) begin
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 1'b0, 1'b0, rs);
                check($sformatf("vec%0d_bresp", i), rs, vecs[i].exp_resp);
            end else begin
                axi_read(vecs[i].addr, 1'b0, rd, rs);
                check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_data);
                check($sformatf("vec%0d_rresp", i), rs, vecs[i].exp_resp);
            end
        end
        check("table_args", args_o, {32'hCAFEF00D, 32'h0, 32'hDEAD1211, 32'hAA3456DD});
        check("table_start", ap_start_o, 1'b0);
        axi_read(6'h18, 1'b0, rd, rs);
        check("arg2_untouched", rd, 32'h0);

        // ap_start only via WSTRB[0], cleared the cycle after ap_ready.
        axi_write(6'h00, 32'hFFFFFFFF, 4'hE, 1'b0, 1'b0, rs);
        check("start_nostrb", ap_start_o, 1'b0);
        axi_write(6'h00, 32'h00000001, 4'h1, 1'b0, 1'b0, rs);
        check("start_set", ap_start_o, 1'b1);
        axi_read(6'h00, 1'b0, rd, rs);
        check("ctrl_start_rd", rd, 32'h00000001);
        @(negedge clock); ap_ready_i = 1'b1;
        @(negedge clock); ap_ready_i = 1'b0;
        check("start_clr", ap_start_o, 1'b0);
        axi_write(6'h00, 32'h00000001, 4'h1, 1'b1, 1'b0, rs);
        check("start_set_wins", ap_start_o, 1'b1);
        @(negedge clock); ap_ready_i = 1'b1;
        @(negedge clock); ap_ready_i = 1'b0;
        check("start_clr2", ap_start_o, 1'b0);

        // ap_done sticky, clear-on-read, set wins over the read clear.
        @(negedge clock); ap_done_i = 1'b1;
        @(negedge clock); ap_done_i = 1'b0;
        axi_read(6'h00, 1'b0, rd, rs);
        check("done_rd1", rd, 32'h00000002);
        axi_read(6'h00, 1'b0, rd, rs);
        check("done_rd2", rd, 32'h00000000);
        ap_idle_i = 1'b1;
        axi_read(6'h00, 1'b0, rd, rs);
        check("idle_rd", rd, 32'h00000004);
        @(negedge clock); ap_done_i = 1'b1;
        @(negedge clock); ap_done_i = 1'b0;
        axi_read(6'h00, 1'b1, rd, rs);
        check("done_collide_rd", rd, 32'h00000006);
        axi_read(6'h00, 1'b0, rd, rs);
        check("done_kept_rd", rd, 32'h00000006);
        axi_read(6'h00, 1'b0, rd, rs);
        check("done_cleared_rd", rd, 32'h00000004);
        ap_idle_i = 1'b0;

        // B backpressure with a concurrent read, then reset in W_RESP.
        axi_write(6'h18, 32'h55AA55AA, 4'hF, 1'b0, 1'b1, rs);
        check("bp_bresp", rs, 2'b00);
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            check($sformatf("bp_hold%0d", c), {bvalid, bresp, awready}, {1'b1, 2'b00, 1'b0});
        end
        axi_read(6'h10, 1'b0, rd, rs);
        check("bp_read", {rd, rs}, {32'hAA3456DD, 2'b00});
        check("bp_still", {bvalid, awready}, {1'b1, 1'b0});
        check("bp_args", args_o, {32'hCAFEF00D, 32'h55AA55AA, 32'hDEAD1211, 32'hAA3456DD});
        #2 reset = 1'b0;
        #1;
        check("mid_rst_bvalid", bvalid, 1'b0);
        check("mid_rst_args", args_o, '0);
        check("mid_rst_ready", {awready, arready}, 2'b11);
        @(negedge clock);
        reset = 1'b1;
        axi_read(6'h18, 1'b0, rd, rs);
        check("post_rst_arg2", {rd, rs}, {32'h0, 2'b00});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
